// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the rx-side ASCII command parser: ASCII codes,
// FSM state encoding, field limits and small datapath helpers.
package uart_cmd_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_C  = 8'h43;
    localparam logic [7:0] ASC_M  = 8'h4D;
    localparam logic [7:0] ASC_S  = 8'h53;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_0  = 8'h30;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] SEC_MAX  = 7'd59;

    // Only the four command letters are folded; other lowercase bytes stay errors.
    function automatic logic [7:0] fold_case(input logic [7:0] b, input logic en);
        if (en && (b == 8'h72 || b == 8'h63 || b == 8'h6D || b == 8'h73))
            return b - 8'h20;
        return b;
    endfunction

    function automatic logic [6:0] mul10_add(input logic [6:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + {3'b000, d};
    endfunction

endpackage

// File: rtl/ascii_digit_dec.sv
// Combinational ASCII '0'..'9' detector and value extractor.
module ascii_digit_dec
    import uart_cmd_parser_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_digit,
    output logic [3:0] o_digit
);

    // The low nibble of 0x30..0x39 is the digit value itself.
    assign o_is_digit = (i_byte >= ASC_0) && (i_byte <= ASC_0 + 8'd9);
    assign o_digit    = o_is_digit ? i_byte[3:0] : 4'd0;

endmodule

// File: rtl/uart_cmd_parser.sv
// Pops bytes from the rx FIFO, turns R/C/M into control pulses and
// "Shhmmss<CR|LF>" into a range-checked time-set for the watch/timer.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = 100_000_000,
    parameter bit          ACCEPT_LOWER = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_pop,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       parse_err
);

    localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_k;
    logic [6:0]      r_acc_hour, r_acc_min, r_acc_sec;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_run, r_clear, r_mode, r_set_valid, r_err;
    logic [4:0]      r_set_hour;
    logic [5:0]      r_set_min, r_set_sec;

    logic [7:0]      w_byte;
    logic            w_is_digit;
    logic [3:0]      w_digit;
    logic            w_pop, w_timeout, w_fields_ok, w_is_term;
    logic            w_run, w_clear, w_mode, w_err, w_commit, w_start, w_acc_en;

    assign w_byte = fold_case(rx_data, ACCEPT_LOWER);

    ascii_digit_dec u_digit_dec (
        .i_byte     (w_byte),
        .o_is_digit (w_is_digit),
        .o_digit    (w_digit)
    );

    assign w_pop       = !rx_empty && (r_state == ST_IDLE || r_state == ST_COLLECT);
    assign w_timeout   = (r_state == ST_COLLECT) && !w_pop && (r_to_cnt == TO_MAX);
    assign w_is_term   = (w_byte == ASC_CR) || (w_byte == ASC_LF);
    assign w_fields_ok = (r_acc_hour <= HOUR_MAX) && (r_acc_min <= MIN_MAX) &&
                         (r_acc_sec <= SEC_MAX);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_clear     = 1'b0;
        w_mode      = 1'b0;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_start     = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    case (w_byte)
                        ASC_R:                  w_run   = 1'b1;
                        ASC_C:                  w_clear = 1'b1;
                        ASC_M:                  w_mode  = 1'b1;
                        ASC_S: begin
                            w_start     = 1'b1;
                            w_state_nxt = ST_COLLECT;
                        end
                        ASC_CR, ASC_LF, ASC_SP: begin end
                        default:                w_err   = 1'b1;
                    endcase
                end
            end
            ST_COLLECT: begin
                if (w_pop) begin
                    if (r_k < 3'd6) begin
                        if (w_is_digit) begin
                            w_acc_en = 1'b1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (w_is_term) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (w_fields_ok) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_EMIT;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EMIT:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Pulses are registered from the decision cycle, giving pop+1 timing and
    // set_valid coinciding with the EMIT state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k         <= 3'd0;
            r_acc_hour  <= 7'd0;
            r_acc_min   <= 7'd0;
            r_acc_sec   <= 7'd0;
            r_to_cnt    <= '0;
            r_run       <= 1'b0;
            r_clear     <= 1'b0;
            r_mode      <= 1'b0;
            r_set_valid <= 1'b0;
            r_err       <= 1'b0;
            r_set_hour  <= 5'd0;
            r_set_min   <= 6'd0;
            r_set_sec   <= 6'd0;
        end else begin
            r_run       <= w_run;
            r_clear     <= w_clear;
            r_mode      <= w_mode;
            r_set_valid <= w_commit;
            r_err       <= w_err;

            if (w_pop)
                r_to_cnt <= '0;
            else if (r_state == ST_COLLECT && r_to_cnt != TO_MAX)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_start)
                r_k <= 3'd0;
            else if (w_acc_en)
                r_k <= r_k + 3'd1;

            // Even index starts a fresh field, odd index appends the units digit.
            if (w_acc_en) begin
                case (r_k[2:1])
                    2'd0:    r_acc_hour <= mul10_add(r_k[0] ? r_acc_hour : 7'd0, w_digit);
                    2'd1:    r_acc_min  <= mul10_add(r_k[0] ? r_acc_min  : 7'd0, w_digit);
                    default: r_acc_sec  <= mul10_add(r_k[0] ? r_acc_sec  : 7'd0, w_digit);
                endcase
            end

            if (w_commit) begin
                r_set_hour <= r_acc_hour[4:0];
                r_set_min  <= r_acc_min[5:0];
                r_set_sec  <= r_acc_sec[5:0];
            end
        end
    end

    assign rx_pop    = w_pop;
    assign cmd_run   = r_run;
    assign cmd_clear = r_clear;
    assign cmd_mode  = r_mode;
    assign set_valid = r_set_valid;
    assign set_hour  = r_set_hour;
    assign set_min   = r_set_min;
    assign set_sec   = r_set_sec;
    assign parse_err = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a queue models the rx FIFO, every
// cycle's pulses are logged and compared against hand-derived cycle offsets.
module tb_uart_cmd_parser;

    localparam int unsigned TO    = 50;
    localparam int          B_RUN = 4;
    localparam int          B_CLR = 3;
    localparam int          B_MOD = 2;
    localparam int          B_SV  = 1;
    localparam int          B_ERR = 0;
    localparam int          LOG_N = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       rx_pop, cmd_run, cmd_clear, cmd_mode, set_valid, parse_err;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYC(TO), .ACCEPT_LOWER(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_pop    (rx_pop),
        .cmd_run   (cmd_run),
        .cmd_clear (cmd_clear),
        .cmd_mode  (cmd_mode),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .parse_err (parse_err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         multi = 0;
    int         pops[$];
    logic [7:0] fifo[$];
    logic [4:0] plog [0:LOG_N-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string s);
        foreach (s[i]) fifo.push_back(s[i]);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic cycle();
        @(negedge clk);
        rx_empty = (fifo.size() == 0);
        rx_data  = (fifo.size() == 0) ? 8'h00 : fifo[0];
        #1;
        if (cyc < LOG_N) begin
            plog[cyc] = {cmd_run, cmd_clear, cmd_mode, set_valid, parse_err};
            if ($countones(plog[cyc]) > 1) multi++;
        end
        if (rx_pop) begin
            pops.push_back(cyc);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic int pop_at(input int i);
        if (i < 0 || i >= pops.size()) return -1000;
        return pops[i];
    endfunction

    function automatic logic pulse(input int c, input int b);
        if (c < 0 || c >= LOG_N || c >= cyc) return 1'b0;
        return plog[c][b];
    endfunction

    function automatic int count(input int b, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (pulse(c, b)) n++;
        return n;
    endfunction

    initial begin
        int p0, t;

        // Reset state
        rst = 1'b0;
        run(3);
        check("reset_pulses", 32'(plog[cyc-1]), 0);
        check("reset_hour", 32'(set_hour), 0);
        check("reset_min", 32'(set_min), 0);
        check("reset_sec", 32'(set_sec), 0);
        rst = 1'b1;
        run(2);

        // 1: single-char commands back-to-back
        pops.delete();
        push("RCM");
        run(6);
        p0 = pop_at(0);
        check("t1_pops", 32'(pops.size()), 3);
        check("t1_b2b", 32'(pop_at(2) - p0), 2);
        check("t1_run_at", 32'(pulse(p0 + 1, B_RUN)), 1);
        check("t1_clear_at", 32'(pulse(p0 + 2, B_CLR)), 1);
        check("t1_mode_at", 32'(pulse(p0 + 3, B_MOD)), 1);
        check("t1_run_cnt", 32'(count(B_RUN, p0, cyc - 1)), 1);
        check("t1_clear_cnt", 32'(count(B_CLR, p0, cyc - 1)), 1);
        check("t1_mode_cnt", 32'(count(B_MOD, p0, cyc - 1)), 1);

        // 2: valid set, followed by 'R' which must wait out CHECK and EMIT
        pops.delete();
        push("S123456\rR");
        run(16);
        t = pop_at(7);
        check("t2_pops", 32'(pops.size()), 9);
        check("t2_sv_before", 32'(pulse(t + 1, B_SV)), 0);
        check("t2_sv_at", 32'(pulse(t + 2, B_SV)), 1);
        check("t2_sv_cnt", 32'(count(B_SV, pop_at(0), cyc - 1)), 1);
        check("t2_err_cnt", 32'(count(B_ERR, pop_at(0), cyc - 1)), 0);
        check("t2_no_pop_check_emit", 32'(pop_at(8) - t), 3);
        check("t2_run_after", 32'(pulse(pop_at(8) + 1, B_RUN)), 1);
        check("t2_hour", 32'(set_hour), 12);
        check("t2_min", 32'(set_min), 34);
        check("t2_sec", 32'(set_sec), 56);

        // 3: hour 24 out of range, fields hold
        pops.delete();
        push("S245959\n");
        run(12);
        t = pop_at(7);
        check("t3_err_at", 32'(pulse(t + 2, B_ERR)), 1);
        check("t3_err_cnt", 32'(count(B_ERR, pop_at(0), cyc - 1)), 1);
        check("t3_sv_cnt", 32'(count(B_SV, pop_at(0), cyc - 1)), 0);
        check("t3_hour", 32'(set_hour), 12);
        check("t3_min", 32'(set_min), 34);
        check("t3_sec", 32'(set_sec), 56);

        // 4: non-digit mid-sequence; trailing digits rejected in IDLE, CR ignored
        pops.delete();
        push("S12a456\r");
        run(14);
        t = pop_at(3);
        check("t4_pops", 32'(pops.size()), 8);
        check("t4_err_at", 32'(pulse(t + 1, B_ERR)), 1);
        check("t4_err_last", 32'(pulse(t + 4, B_ERR)), 1);
        check("t4_err_cnt", 32'(count(B_ERR, pop_at(0), cyc - 1)), 4);
        check("t4_sv_cnt", 32'(count(B_SV, pop_at(0), cyc - 1)), 0);

        // 5: timeout after 51 idle cycles, then R and lowercase m
        pops.delete();
        push("S12");
        run(60);
        t = pop_at(2);
        check("t5_pops", 32'(pops.size()), 3);
        check("t5_err_early", 32'(pulse(t + 51, B_ERR)), 0);
        check("t5_err_at", 32'(pulse(t + 52, B_ERR)), 1);
        check("t5_err_cnt", 32'(count(B_ERR, pop_at(0), cyc - 1)), 1);
        pops.delete();
        push("Rm");
        run(5);
        p0 = pop_at(0);
        check("t5_run_at", 32'(pulse(p0 + 1, B_RUN)), 1);
        check("t5_lower_mode_at", 32'(pulse(p0 + 2, B_MOD)), 1);

        // 6: reset while 4 digits are collected
        pops.delete();
        push("S1234");
        run(7);
        check("t6_pops", 32'(pops.size()), 5);
        rst = 1'b0;
        run(1);
        check("t6_rst_pulses", 32'(plog[cyc-1]), 0);
        check("t6_rst_hour", 32'(set_hour), 0);
        check("t6_rst_min", 32'(set_min), 0);
        check("t6_rst_sec", 32'(set_sec), 0);
        rst = 1'b1;
        pops.delete();
        push("S000000\r");
        run(12);
        t = pop_at(7);
        check("t6_sv_at", 32'(pulse(t + 2, B_SV)), 1);
        check("t6_err_cnt", 32'(count(B_ERR, pop_at(0), cyc - 1)), 0);
        check("t6_hour", 32'(set_hour), 0);
        check("t6_min", 32'(set_min), 0);
        check("t6_sec", 32'(set_sec), 0);

        check("one_hot_pulses", 32'(multi), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
